// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline front end.
//   word_t        : 32-bit machine word / byte address
//   fetch_state_t : fetch sequencer states
//   PC_STEP       : sequential PC increment in bytes
//   INSTR_NOP     : encoding loaded into IF/ID when it is flushed
package mips_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam word_t PC_STEP   = 32'd4;
    localparam word_t INSTR_NOP = 32'h0000_0000;

    // Force a byte address onto a word boundary.
    function automatic word_t alignWord(input word_t addr);
        return {addr[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk, rst               : clock, asynchronous active-high reset
//   capture                : load pcIn/pc4In/instrIn and mark the entry valid
//   clear                  : invalidate the entry and load a NOP (wins over capture)
//   pcIn, pc4In, instrIn   : fetched PC, PC+4 and instruction word
//   ifIdPc, ifIdPc4,
//   ifIdInstr, ifIdValid   : registered IF/ID contents
// With neither capture nor clear asserted the register holds.
module if_id_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        capture,
    input  logic        clear,
    input  logic [31:0] pcIn,
    input  logic [31:0] pc4In,
    input  logic [31:0] instrIn,
    output logic [31:0] ifIdPc,
    output logic [31:0] ifIdPc4,
    output logic [31:0] ifIdInstr,
    output logic        ifIdValid
);

    // PC fields are left untouched on clear; only valid/instr matter downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifIdPc    <= '0;
            ifIdPc4   <= '0;
            ifIdInstr <= INSTR_NOP;
            ifIdValid <= 1'b0;
        end else if (clear) begin
            ifIdInstr <= INSTR_NOP;
            ifIdValid <= 1'b0;
        end else if (capture) begin
            ifIdPc    <= pcIn;
            ifIdPc4   <= pc4In;
            ifIdInstr <= instrIn;
            ifIdValid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, BOOT/RUN/HALT sequencer and IF/ID register.
// Parameters:
//   RESET_PC   : PC loaded on reset
//   IMEM_BYTES : instruction memory size; PC >= IMEM_BYTES is out of range
// Ports:
//   clk, rst                          : clock, asynchronous active-high reset
//   stall, flush                      : hazard unit hold / IF/ID invalidate
//   redirect_valid, redirect_target   : taken branch/jump and its byte address
//   imem_addr, imem_instr             : combinational instruction memory port
//   if_id_pc, if_id_pc4, if_id_instr,
//   if_id_valid                       : IF/ID register contents
//   misalign_err                      : sticky, set by a redirect to a non-word address
//   halted                            : sequencer is in HALT
// Optional build macro FETCH_STAT_EN adds fetch_count / flush_count statistics outputs.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        misalign_err,
    output logic        halted
`ifdef FETCH_STAT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] flush_count
`endif
);

    localparam word_t IMEM_LIMIT = 32'(IMEM_BYTES);

    fetch_state_t state;
    fetch_state_t stateNext;

    word_t pc;
    word_t pcPlus4;
    word_t targetAligned;
    word_t pcCandidate;
    logic  targetMisaligned;
    logic  candidateInRange;
    logic  pcAdvance;

    logic  pcLoad;
    logic  capture;
    logic  clear;
    logic  misalignSet;

    // Candidate next PC; the 32-bit add wraps naturally.
    assign pcPlus4          = pc + PC_STEP;
    assign targetAligned    = alignWord(redirect_target);
    assign targetMisaligned = (redirect_target[1:0] != 2'b00);
    assign pcCandidate      = redirect_valid ? targetAligned : pcPlus4;
    assign candidateInRange = (pcCandidate < IMEM_LIMIT);
    // A redirect moves the PC even while the hazard unit stalls.
    assign pcAdvance        = !stall || redirect_valid;

    assign imem_addr = pc;
    assign halted    = (state == HALT);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BOOT;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic.
    always_comb begin
        stateNext = state;
        unique case (state)
            BOOT: stateNext = RUN;
            RUN: begin
                if (pcAdvance && !candidateInRange) begin
                    stateNext = HALT;
                end
            end
            HALT: begin
                if (redirect_valid && candidateInRange) begin
                    stateNext = RUN;
                end
            end
            default: stateNext = BOOT;
        endcase
    end

    // Datapath controls per state. Entering HALT keeps the last in-range PC.
    always_comb begin
        pcLoad      = 1'b0;
        capture     = 1'b0;
        clear       = 1'b0;
        misalignSet = 1'b0;
        unique case (state)
            RUN: begin
                pcLoad      = pcAdvance && candidateInRange;
                capture     = !stall && !flush;
                clear       = flush;
                misalignSet = redirect_valid && targetMisaligned;
            end
            HALT: begin
                pcLoad      = redirect_valid && candidateInRange;
                clear       = 1'b1;
                misalignSet = redirect_valid && targetMisaligned;
            end
            default: begin
            end
        endcase
    end

    // PC register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (pcLoad) begin
            pc <= pcCandidate;
        end
    end

    // Sticky misaligned-redirect flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_err <= 1'b0;
        end else if (misalignSet) begin
            misalign_err <= 1'b1;
        end
    end

    if_id_reg u_ifId (
        .clk       (clk),
        .rst       (rst),
        .capture   (capture),
        .clear     (clear),
        .pcIn      (pc),
        .pc4In     (pcPlus4),
        .instrIn   (imem_instr),
        .ifIdPc    (if_id_pc),
        .ifIdPc4   (if_id_pc4),
        .ifIdInstr (if_id_instr),
        .ifIdValid (if_id_valid)
    );

`ifdef FETCH_STAT_EN
    // Capture and valid-flush statistics, wrapping modulo 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count <= '0;
            flush_count <= '0;
        end else begin
            if (capture) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (flush && if_id_valid) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a cycle-level reference model predicts the
// outputs after every clock edge; a monitor compares them on the falling edge.
module tb_fetch_stage;

    localparam int unsigned IMEM = 4096;
    localparam int ST_BOOT = 0;
    localparam int ST_RUN  = 1;
    localparam int ST_HALT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        misalign_err;
    logic        halted;
`ifdef FETCH_STAT_EN
    logic [31:0] fetch_count;
    logic [31:0] flush_count;
`endif

    logic [31:0] mem [0:1023];

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ipc;
        logic [31:0] ipc4;
        logic [31:0] ins;
        logic        vld;
        logic        mis;
        logic        hlt;
        logic [31:0] fc;
        logic [31:0] flc;
    } exp_t;

    exp_t expQ[$];

    // Reference model state.
    int          mState;
    logic [31:0] mPc, mIpc, mIpc4, mIns, mFc, mFlc;
    logic        mVld, mMis;

    fetch_stage #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_BYTES (IMEM)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush           (flush),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_instr      (imem_instr),
        .if_id_pc        (if_id_pc),
        .if_id_pc4       (if_id_pc4),
        .if_id_instr     (if_id_instr),
        .if_id_valid     (if_id_valid),
        .misalign_err    (misalign_err),
        .halted          (halted)
`ifdef FETCH_STAT_EN
        ,
        .fetch_count     (fetch_count),
        .flush_count     (flush_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memRead(input logic [31:0] a);
        if (a < 32'(IMEM)) return mem[a[11:2]];
        return 32'hDEAD_BEEF;
    endfunction

    assign imem_instr = memRead(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic modelReset();
        mState = ST_BOOT;
        mPc = 32'h0; mIpc = 32'h0; mIpc4 = 32'h0; mIns = 32'h0;
        mVld = 1'b0; mMis = 1'b0; mFc = 32'h0; mFlc = 32'h0;
    endtask

    // One clock edge of behaviour, written from the fetch rules.
    task automatic modelStep(input bit r, input bit s, input bit f, input bit rv,
                             input logic [31:0] rt);
        logic [31:0] tgt, nxt;
        exp_t e;
        tgt = rt & 32'hFFFF_FFFC;
        if (r) begin
            modelReset();
        end else if (mState == ST_BOOT) begin
            mState = ST_RUN;
        end else begin
            if (rv && rt[1:0] != 2'b00) mMis = 1'b1;
            if (f && mVld) mFlc = mFlc + 32'd1;
            if (mState == ST_RUN) begin
                nxt = rv ? tgt : mPc + 32'd4;
                if (f) begin
                    mVld = 1'b0; mIns = 32'h0;
                end else if (!s) begin
                    mIpc = mPc; mIpc4 = mPc + 32'd4; mIns = memRead(mPc);
                    mVld = 1'b1; mFc = mFc + 32'd1;
                end
                if (!s || rv) begin
                    if (nxt >= 32'(IMEM)) mState = ST_HALT;
                    else mPc = nxt;
                end
            end else begin
                mVld = 1'b0; mIns = 32'h0;
                if (rv && tgt < 32'(IMEM)) begin
                    mPc = tgt; mState = ST_RUN;
                end
            end
        end
        e.pc = mPc; e.ipc = mIpc; e.ipc4 = mIpc4; e.ins = mIns; e.vld = mVld;
        e.mis = mMis; e.hlt = (mState == ST_HALT); e.fc = mFc; e.flc = mFlc;
        expQ.push_back(e);
    endtask

    // Drive one cycle of inputs after the falling edge and record the prediction.
    task automatic cyc(input bit r, input bit s, input bit f, input bit rv,
                       input logic [31:0] rt);
        @(negedge clk);
        #1;
        rst = r; stall = s; flush = f; redirect_valid = rv; redirect_target = rt;
        modelStep(r, s, f, rv, rt);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 32'h0);
    endtask

    // Monitor: compares the DUT against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                chk("imem_addr", imem_addr, e.pc);
                chk("if_id_valid", 32'(if_id_valid), 32'(e.vld));
                chk("if_id_instr", if_id_instr, e.ins);
                if (e.vld) begin
                    chk("if_id_pc", if_id_pc, e.ipc);
                    chk("if_id_pc4", if_id_pc4, e.ipc4);
                end
                chk("misalign_err", 32'(misalign_err), 32'(e.mis));
                chk("halted", 32'(halted), 32'(e.hlt));
`ifdef FETCH_STAT_EN
                chk("fetch_count", fetch_count, e.fc);
                chk("flush_count", flush_count, e.flc);
`endif
            end
        end
    end

    initial begin
        int roll;
        logic [31:0] tgt;
        rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0;
        redirect_target = 32'h0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[0] = 32'h0022_1821;
        mem[1] = 32'h0001_2821;
        modelReset();

        // Reset, boot, first captures, stall at pc=8.
        cyc(1, 0, 0, 0, 32'h0);
        cyc(1, 0, 0, 0, 32'h0);
        idle(3);
        cyc(0, 1, 0, 0, 32'h0);
        cyc(0, 1, 0, 0, 32'h0);
        idle(1);
        // Flush + stall + redirect together at pc=12.
        cyc(0, 1, 1, 1, 32'd32);
        idle(2);
        // Misaligned redirect, sticky flag, cleared only by reset.
        cyc(0, 0, 0, 1, 32'h0000_0022);
        idle(2);
        cyc(0, 0, 0, 1, 32'h0000_0040);
        idle(1);
        cyc(0, 0, 1, 0, 32'h0);
        cyc(1, 0, 0, 1, 32'h0000_0100);
        idle(3);
        // Run up to the end of memory, halt, reject an out-of-range wakeup, resume at 0.
        cyc(0, 0, 0, 1, 32'd4080);
        idle(7);
        cyc(0, 0, 0, 1, 32'd5000);
        idle(2);
        cyc(0, 0, 0, 1, 32'h0);
        idle(3);
        cyc(0, 0, 1, 0, 32'h0);
        idle(2);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            roll = int'($urandom_range(0, 99));
            if ($urandom_range(0, 7) == 0) tgt = 32'(IMEM) + $urandom_range(0, 255);
            else tgt = $urandom_range(0, IMEM - 1);
            if ($urandom_range(0, 3) != 0) tgt = tgt & 32'hFFFF_FFFC;
            cyc(roll == 0,
                $urandom_range(0, 4) == 0,
                $urandom_range(0, 9) == 0,
                $urandom_range(0, 9) == 0,
                tgt);
        end

        cyc(0, 0, 0, 0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
